counter_run_ctrl: RTL and testbench
===================================

// Module: counter_run_ctrl
// PURPOSE
//   Run/pause/clear controller for the 0-30 decimal counter. Debounces three raw push-buttons,
//   turns them into single-cycle press events and drives the counter's enable and clear inputs
//   through a 4-state FSM. Sits between the board buttons and the counter; it watches the
//   counter's count output so it can stop automatically at the terminal value.
// PARAMETERS
//   DEBOUNCE_CYCLES  20'd1_000_000  cycles a synchronised button must stay stable before it is accepted (10 ms @100 MHz)
//   MAX_COUNT        5'd30          terminal count; reaching it ends the run when AUTO_STOP=1
//   AUTO_STOP        1'b1           1: stop in DONE at MAX_COUNT; 0: stay in RUN and let the counter wrap
// PORTS
//   clk          in   1  system clock, 100 MHz
//   rst          in   1  synchronous, active-high reset
//   btn_start    in   1  raw start/resume button, active-high, asynchronous to clk
//   btn_pause    in   1  raw pause button, active-high, asynchronous to clk
//   btn_clear    in   1  raw clear button, active-high, asynchronous to clk
//   count        in   5  current value from the counter
//   cnt_enable   out  1  counter enable (level)
//   cnt_clear    out  1  counter clear, 1-cycle pulse
//   state        out  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   done         out  1  high while state==DONE
// BEHAVIOUR
//   Reset: state=IDLE; cnt_clear=0, done=0, cnt_enable=0; sync FFs, debounce counters and levels cleared.
//   Input path, per button:
//     - 2-FF synchroniser.
//     - Debounce counter: while sync != level, count up; when it reaches DEBOUNCE_CYCLES-1, level<=sync and the counter clears.
//     - Counter clears whenever sync == level.
//     - Press pulse = level rising edge, exactly 1 cycle.
//     - Press latency: raw edge -> pulse = 2 + DEBOUNCE_CYCLES cycles. A release produces no pulse.
//   Simultaneous press pulses: priority clear > pause > start; lower-priority pulses that cycle are dropped.
//   FSM (registered, evaluated on press pulses of the same cycle):
//     IDLE : clear -> IDLE with cnt_clear; start -> RUN; pause ignored.
//     RUN  : clear -> IDLE with cnt_clear; pause -> PAUSE.
//            Otherwise, if AUTO_STOP && count==MAX_COUNT -> DONE. Start is ignored.
//     PAUSE: clear -> IDLE with cnt_clear; start -> RUN (resume, count kept); pause ignored.
//     DONE : clear -> IDLE with cnt_clear; start -> RUN with cnt_clear (restart from 0); pause ignored.
//   cnt_clear: registered, asserted the cycle after the triggering pulse, for exactly 1 cycle.
//   cnt_enable: combinational = (state==RUN) && !(AUTO_STOP && count==MAX_COUNT).
//     It drops in the same cycle count reaches MAX_COUNT, so the counter never wraps when AUTO_STOP=1.
//   done: registered, equals (state==DONE).
//   count > MAX_COUNT is treated as below MAX_COUNT (no stop); only the equality compare is used.
//   rst mid-debounce or mid-run: everything returns to reset values on the next edge.
//     A button still held after reset is accepted once its debounce window completes (level starts at 0).
// TESTING (DEBOUNCE_CYCLES=4 in sim)
//   1 rst high 2 cycles -> state=00, cnt_enable=0, cnt_clear=0, done=0 on the first edge after rst.
//   2 btn_start high 3 cycles, then low -> no pulse, state stays 00.
//     btn_start held 10 cycles -> state=01 at cycle 7, cnt_enable=1.
//   3 RUN, count driven 29 then 30 -> cnt_enable=0 in the count=30 cycle; state=11 and done=1 next edge.
//     btn_start then -> cnt_clear 1-cycle pulse, state=01.
//   4 RUN, pause press -> state=10, cnt_enable=0, count held.
//     start press -> state=01, no cnt_clear.
//   5 RUN, clear and pause press edges aligned -> state=00, single cnt_clear pulse, PAUSE never entered.
//   6 AUTO_STOP=0, RUN, count=30 -> cnt_enable stays 1, state stays 01.
//     Also: rst asserted in RUN -> state=00 next edge.

Source files
------------

// File: rtl/counter_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : counter_run_ctrl
//  Purpose  : Debounced run/pause/clear controller for the 0-30 decimal counter
//  Revision : 1.0 - initial release
// ============================================================================
module counter_run_ctrl #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
  parameter logic [4:0]  MAX_COUNT       = 5'd30,
  parameter logic        AUTO_STOP       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_clear,
  input  logic [4:0] count,
  output logic       cnt_enable,
  output logic       cnt_clear,
  output logic [1:0] state,
  output logic       done
);

  localparam logic [19:0] DB_LAST = DEBOUNCE_CYCLES - 20'd1;
  localparam int unsigned NUM_BTN = 3;
  localparam int unsigned IDX_START = 0;
  localparam int unsigned IDX_PAUSE = 1;
  localparam int unsigned IDX_CLEAR = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;

  assign btn_raw = {btn_clear, btn_pause, btn_start};

  // Per button: 2-FF synchroniser, stability counter, rising-edge press pulse.
  generate
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      logic        sync1_q;
      logic        sync2_q;
      logic        level_q;
      logic        level_d;
      logic        press_q;
      logic        press_d;
      logic [19:0] deb_cnt_q;
      logic [19:0] deb_cnt_d;

      always_comb begin
        level_d   = level_q;
        deb_cnt_d = 20'd0;
        if (sync2_q != level_q) begin
          if (deb_cnt_q == DB_LAST) begin
            level_d = sync2_q;
          end else begin
            deb_cnt_d = deb_cnt_q + 20'd1;
          end
        end
        press_d = level_d & ~level_q;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_q   <= 1'b0;
          sync2_q   <= 1'b0;
          level_q   <= 1'b0;
          press_q   <= 1'b0;
          deb_cnt_q <= 20'd0;
        end else begin
          sync1_q   <= btn_raw[i];
          sync2_q   <= sync1_q;
          level_q   <= level_d;
          press_q   <= press_d;
          deb_cnt_q <= deb_cnt_d;
        end
      end

      assign press[i] = press_q;
    end
  endgenerate

  logic clear_ev;
  logic pause_ev;
  logic start_ev;
  logic at_max;

  // Clear outranks pause, pause outranks start; losers are simply dropped.
  assign clear_ev = press[IDX_CLEAR];
  assign pause_ev = press[IDX_PAUSE] & ~press[IDX_CLEAR];
  assign start_ev = press[IDX_START] & ~press[IDX_PAUSE] & ~press[IDX_CLEAR];
  assign at_max   = AUTO_STOP && (count == MAX_COUNT);

  state_t state_q;
  state_t state_d;
  logic   cnt_clear_q;
  logic   cnt_clear_d;
  logic   done_q;
  logic   done_d;

  always_comb begin
    state_d     = state_q;
    cnt_clear_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear_ev) begin
          cnt_clear_d = 1'b1;
        end else if (start_ev) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (clear_ev) begin
          state_d     = S_IDLE;
          cnt_clear_d = 1'b1;
        end else if (pause_ev) begin
          state_d = S_PAUSE;
        end else if (at_max) begin
          state_d = S_DONE;
        end
      end
      S_PAUSE: begin
        if (clear_ev) begin
          state_d     = S_IDLE;
          cnt_clear_d = 1'b1;
        end else if (start_ev) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        // Restart from DONE also zeroes the counter.
        if (clear_ev) begin
          state_d     = S_IDLE;
          cnt_clear_d = 1'b1;
        end else if (start_ev) begin
          state_d     = S_RUN;
          cnt_clear_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_clear_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_clear_q <= cnt_clear_d;
      done_q      <= done_d;
    end
  end

  assign state      = state_q;
  assign cnt_clear  = cnt_clear_q;
  assign done       = done_q;
  assign cnt_enable = (state_q == S_RUN) && !at_max;

endmodule
`default_nettype wire

// File: tb/tb_counter_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_run_ctrl
//  Purpose  : Directed scoreboard bench for counter_run_ctrl (debounce = 4)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_counter_run_ctrl;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_start, btn_pause, btn_clear;
  logic [4:0] count;
  logic       cnt_enable, cnt_clear, done;
  logic [1:0] state;

  logic       btn_start_ns, btn_pause_ns, btn_clear_ns;
  logic [4:0] count_ns;
  logic       cnt_enable_ns, cnt_clear_ns, done_ns;
  logic [1:0] state_ns;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    bit         sel;
    logic [1:0] st;
    logic       en;
    logic       clr;
    logic       dn;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  counter_run_ctrl #(
    .DEBOUNCE_CYCLES(20'd4),
    .MAX_COUNT      (5'd30),
    .AUTO_STOP      (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_pause (btn_pause),
    .btn_clear (btn_clear),
    .count     (count),
    .cnt_enable(cnt_enable),
    .cnt_clear (cnt_clear),
    .state     (state),
    .done      (done)
  );

  counter_run_ctrl #(
    .DEBOUNCE_CYCLES(20'd4),
    .MAX_COUNT      (5'd30),
    .AUTO_STOP      (1'b0)
  ) dut_ns (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start_ns),
    .btn_pause (btn_pause_ns),
    .btn_clear (btn_clear_ns),
    .count     (count_ns),
    .cnt_enable(cnt_enable_ns),
    .cnt_clear (cnt_clear_ns),
    .state     (state_ns),
    .done      (done_ns)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input bit sel, input logic [1:0] st,
                      input logic en, input logic clr, input logic dn);
    exp_t e;
    e.tag = tag; e.sel = sel; e.st = st; e.en = en; e.clr = clr; e.dn = dn;
    sb_q.push_back(e);
  endtask

  task automatic check();
    exp_t       e;
    logic [1:0] o_st;
    logic       o_en, o_clr, o_dn;
    n_assert++;
    assert (sb_q.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries expected >=1");
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      o_st  = e.sel ? state_ns      : state;
      o_en  = e.sel ? cnt_enable_ns : cnt_enable;
      o_clr = e.sel ? cnt_clear_ns  : cnt_clear;
      o_dn  = e.sel ? done_ns       : done;
      n_assert++;
      assert (o_st === e.st) else begin
        n_fail++;
        $error("FAIL %s state: observed %b expected %b", e.tag, o_st, e.st);
      end
      n_assert++;
      assert (o_en === e.en) else begin
        n_fail++;
        $error("FAIL %s cnt_enable: observed %b expected %b", e.tag, o_en, e.en);
      end
      n_assert++;
      assert (o_clr === e.clr) else begin
        n_fail++;
        $error("FAIL %s cnt_clear: observed %b expected %b", e.tag, o_clr, e.clr);
      end
      n_assert++;
      assert (o_dn === e.dn) else begin
        n_fail++;
        $error("FAIL %s done: observed %b expected %b", e.tag, o_dn, e.dn);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    btn_start = 1'b0; btn_pause = 1'b0; btn_clear = 1'b0; count = 5'd0;
    btn_start_ns = 1'b0; btn_pause_ns = 1'b0; btn_clear_ns = 1'b0; count_ns = 5'd0;

    // Reset
    push("reset", 1'b0, ST_IDLE, 1'b0, 1'b0, 1'b0);
    push("reset_ns", 1'b1, ST_IDLE, 1'b0, 1'b0, 1'b0);
    step(1);
    check(); check();
    step(1);
    rst = 1'b0;

    // Short glitch (3 cycles) must be rejected
    btn_start = 1'b1;
    step(3);
    btn_start = 1'b0;
    push("glitch", 1'b0, ST_IDLE, 1'b0, 1'b0, 1'b0);
    step(8);
    check();

    // Held start: still IDLE after 6 edges, RUN after the 7th
    btn_start = 1'b1;
    push("start_edge6", 1'b0, ST_IDLE, 1'b0, 1'b0, 1'b0);
    step(6);
    check();
    push("start_edge7", 1'b0, ST_RUN, 1'b1, 1'b0, 1'b0);
    step(1);
    check();
    step(3);
    btn_start = 1'b0;
    push("start_release", 1'b0, ST_RUN, 1'b1, 1'b0, 1'b0);
    step(8);
    check();

    // Terminal count: enable drops combinationally, DONE next edge
    count = 5'd29;
    push("count29", 1'b0, ST_RUN, 1'b1, 1'b0, 1'b0);
    #1;
    check();
    count = 5'd30;
    push("count30", 1'b0, ST_RUN, 1'b0, 1'b0, 1'b0);
    #1;
    check();
    push("done", 1'b0, ST_DONE, 1'b0, 1'b0, 1'b1);
    step(1);
    check();

    // Restart from DONE pulses cnt_clear once
    btn_start = 1'b1;
    push("restart", 1'b0, ST_RUN, 1'b0, 1'b1, 1'b0);
    step(7);
    check();
    count = 5'd0;
    push("restart_after", 1'b0, ST_RUN, 1'b1, 1'b0, 1'b0);
    step(1);
    check();
    btn_start = 1'b0;
    step(8);

    // Pause then resume without clear
    count = 5'd12;
    btn_pause = 1'b1;
    push("pause", 1'b0, ST_PAUSE, 1'b0, 1'b0, 1'b0);
    step(7);
    check();
    btn_pause = 1'b0;
    step(8);
    btn_start = 1'b1;
    push("resume", 1'b0, ST_RUN, 1'b1, 1'b0, 1'b0);
    step(7);
    check();
    push("resume_noclr", 1'b0, ST_RUN, 1'b1, 1'b0, 1'b0);
    step(1);
    check();
    btn_start = 1'b0;
    step(8);

    // Clear and pause together: clear wins, PAUSE never entered
    btn_clear = 1'b1;
    btn_pause = 1'b1;
    push("clr_pause_e6", 1'b0, ST_RUN, 1'b1, 1'b0, 1'b0);
    step(6);
    check();
    push("clr_pause_e7", 1'b0, ST_IDLE, 1'b0, 1'b1, 1'b0);
    step(1);
    check();
    push("clr_pause_e8", 1'b0, ST_IDLE, 1'b0, 1'b0, 1'b0);
    step(1);
    check();
    btn_clear = 1'b0;
    btn_pause = 1'b0;
    step(8);

    // AUTO_STOP=0 instance ignores terminal count; main instance just runs
    count    = 5'd5;
    count_ns = 5'd30;
    btn_start    = 1'b1;
    btn_start_ns = 1'b1;
    push("both_run", 1'b0, ST_RUN, 1'b1, 1'b0, 1'b0);
    push("ns_run30", 1'b1, ST_RUN, 1'b1, 1'b0, 1'b0);
    step(7);
    check(); check();
    push("ns_stay_run", 1'b1, ST_RUN, 1'b1, 1'b0, 1'b0);
    step(3);
    check();

    // Reset while running, button still held
    rst = 1'b1;
    push("rst_run", 1'b0, ST_IDLE, 1'b0, 1'b0, 1'b0);
    push("rst_run_ns", 1'b1, ST_IDLE, 1'b0, 1'b0, 1'b0);
    step(1);
    check(); check();
    rst = 1'b0;
    push("held_e6", 1'b0, ST_IDLE, 1'b0, 1'b0, 1'b0);
    step(6);
    check();
    push("held_e7", 1'b0, ST_RUN, 1'b1, 1'b0, 1'b0);
    step(1);
    check();
    btn_start    = 1'b0;
    btn_start_ns = 1'b0;
    step(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
